// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - shared console constants and the ROM arbiter tag type
package console_pkg;

  localparam logic PORT_PPU = 1'b0;
  localparam logic PORT_SM  = 1'b1;

  localparam int ROM_ADDR_W   = 16;
  localparam int ROM_DATA_W   = 16;
  localparam int ROM_LAT_DFLT = 2;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/rom_arbiter_if.sv
// rtl/rom_arbiter_if.sv - requester and ROM signals of the sprite ROM arbiter
interface rom_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;
  logic              rom_rd;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  // slave is the arbiter, master is the ppu/statemachine/ROM side
  modport slave (
    input  req0, addr0, req1, addr1, rom_data,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_rd, rom_addr
  );

  modport master (
    output req0, addr0, req1, addr1, rom_data,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_rd, rom_addr
  );
endinterface

// File: rtl/rom_arbiter_tag_pipe.sv
// rtl/rom_arbiter_tag_pipe.sv - rom_tag_pipe: latency-matched {valid,id} shift register
module rom_tag_pipe
  import console_pkg::*;
#(
  parameter int DEPTH = ROM_LAT_DFLT
) (
  input  logic clock,
  input  logic reset,
  input  tag_t tag_i,
  output tag_t tail_o
);

  tag_t stage_q [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tail_o = stage_q[DEPTH-1];

endmodule

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - two-port sprite ROM arbiter, port 0 priority with port 1 starvation guard
// Optional debug grant/forced counters under ROM_ARBITER_STATS_EN.
module rom_arbiter
  import console_pkg::*;
#(
  parameter int ADDR_W   = ROM_ADDR_W,
  parameter int DATA_W   = ROM_DATA_W,
  parameter int ROM_LAT  = ROM_LAT_DFLT,
  parameter int MAX_WAIT = 8
) (
  input  logic            clock,
  input  logic            reset,
  rom_arbiter_if.slave    bus
`ifdef ROM_ARBITER_STATS_EN
  ,
  output logic [31:0]     grant_cnt0,
  output logic [31:0]     grant_cnt1,
  output logic [15:0]     forced_cnt
`endif
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic              forced;
  logic              gnt0;
  logic              gnt1;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  tag_t              tag_in;
  tag_t              tail;

  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  always_comb begin
    forced   = bus.req1 && (wait_cnt_q >= MAX_WAIT_C);
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    rom_addr = '0;
    if (forced) begin
      gnt1     = 1'b1;
      rom_addr = bus.addr1;
    end else if (bus.req0) begin
      gnt0     = 1'b1;
      rom_addr = bus.addr0;
    end else if (bus.req1) begin
      gnt1     = 1'b1;
      rom_addr = bus.addr1;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (gnt1 || !bus.req1) wait_cnt_d = '0;
    else if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
  end

  assign tag_in.valid = gnt0 || gnt1;
  assign tag_in.id    = gnt1 ? PORT_SM : PORT_PPU;

  rom_tag_pipe #(.DEPTH(ROM_LAT)) u_tag_pipe (
    .clock  (clock),
    .reset  (reset),
    .tag_i  (tag_in),
    .tail_o (tail)
  );

  // the tail entry names the port that owns this cycle's rom_data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rvalid0_q  <= tail.valid && (tail.id == PORT_PPU);
      rvalid1_q  <= tail.valid && (tail.id == PORT_SM);
      if (tail.valid && (tail.id == PORT_PPU)) rdata0_q <= bus.rom_data;
      if (tail.valid && (tail.id == PORT_SM))  rdata1_q <= bus.rom_data;
    end
  end

  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  assign bus.rom_rd   = gnt0 || gnt1;
  assign bus.rom_addr = rom_addr;
  assign bus.rvalid0  = rvalid0_q;
  assign bus.rvalid1  = rvalid1_q;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;

`ifdef ROM_ARBITER_STATS_EN
  logic [31:0] grant_cnt0_q, grant_cnt1_q;
  logic [15:0] forced_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
      forced_cnt_q <= '0;
    end else begin
      if (gnt0)   grant_cnt0_q <= grant_cnt0_q + 32'd1;
      if (gnt1)   grant_cnt1_q <= grant_cnt1_q + 32'd1;
      if (forced) forced_cnt_q <= forced_cnt_q + 16'd1;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
  assign forced_cnt = forced_cnt_q;
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - directed vector bench for rom_arbiter
module tb_rom_arbiter;

  localparam int LAT = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  rom_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

`ifdef ROM_ARBITER_STATS_EN
  logic [31:0] grant_cnt0, grant_cnt1;
  logic [15:0] forced_cnt;
`endif

  rom_arbiter #(.ADDR_W(16), .DATA_W(16), .ROM_LAT(LAT), .MAX_WAIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef ROM_ARBITER_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
    .forced_cnt (forced_cnt)
`endif
  );

  // ROM model: data = address + 0x1000, LAT cycles after the read
  logic [15:0] apipe [LAT];
  always @(posedge clock) begin
    apipe[0] <= bus.rom_addr;
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign bus.rom_data = apipe[LAT-1] + 16'h1000;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic drive(input logic r0, input logic [15:0] a0, input logic r1, input logic [15:0] a1);
    bus.req0  = r0;
    bus.addr0 = a0;
    bus.req1  = r1;
    bus.addr1 = a1;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        req0;
    logic [15:0] addr0;
    logic        req1;
    logic [15:0] addr1;
    logic        gnt0;
    logic        gnt1;
    logic [15:0] rom_addr;
    logic        rv0;
    logic        rv1;
    logic [15:0] rd0;
    logic [15:0] rd1;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // single port-0 read, then contention with port 0 dropping after its grant
    vecs[0] = '{1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[2] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[3] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1010, 16'h0000};
    vecs[4] = '{1'b1, 16'h0001, 1'b1, 16'h0002, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 16'h1010, 16'h0000};
    vecs[5] = '{1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 16'h1010, 16'h0000};
    vecs[6] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1010, 16'h0000};
    vecs[7] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1001, 16'h0000};
    vecs[8] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1001, 16'h1002};
    vecs[9] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1001, 16'h1002};

    drive(1'b0, 16'h0, 1'b0, 16'h0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
    chk("rst_rom_rd", 32'(bus.rom_rd), 32'd0);
    chk("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
    chk("rst_rdata0", 32'(bus.rdata0), 32'd0);
    chk("rst_rdata1", 32'(bus.rdata1), 32'd0);
    next_cycle();
    reset = 1'b0;

    for (int c = 0; c < 10; c++) begin
      drive(vecs[c].req0, vecs[c].addr0, vecs[c].req1, vecs[c].addr1);
      @(negedge clock);
      chk($sformatf("v%0d_gnt0", c), 32'(bus.gnt0), 32'(vecs[c].gnt0));
      chk($sformatf("v%0d_gnt1", c), 32'(bus.gnt1), 32'(vecs[c].gnt1));
      chk($sformatf("v%0d_rom_rd", c), 32'(bus.rom_rd), 32'(vecs[c].gnt0 | vecs[c].gnt1));
      chk($sformatf("v%0d_rom_addr", c), 32'(bus.rom_addr), 32'(vecs[c].rom_addr));
      chk($sformatf("v%0d_rvalid0", c), 32'(bus.rvalid0), 32'(vecs[c].rv0));
      chk($sformatf("v%0d_rvalid1", c), 32'(bus.rvalid1), 32'(vecs[c].rv1));
      chk($sformatf("v%0d_rdata0", c), 32'(bus.rdata0), 32'(vecs[c].rd0));
      chk($sformatf("v%0d_rdata1", c), 32'(bus.rdata1), 32'(vecs[c].rd1));
      next_cycle();
    end

    // back-to-back streaming on port 0
    for (int k = 0; k < 20; k++) begin
      if (k < 16) drive(1'b1, 16'h0300 + 16'(k), 1'b0, 16'h0);
      else        drive(1'b0, 16'h0, 1'b0, 16'h0);
      @(negedge clock);
      chk($sformatf("s%0d_gnt0", k), 32'(bus.gnt0), (k < 16) ? 32'd1 : 32'd0);
      if (k < 16) chk($sformatf("s%0d_rom_addr", k), 32'(bus.rom_addr), 32'h0300 + 32'(k));
      chk($sformatf("s%0d_rvalid0", k), 32'(bus.rvalid0), (k >= 3 && k < 19) ? 32'd1 : 32'd0);
      chk($sformatf("s%0d_rvalid1", k), 32'(bus.rvalid1), 32'd0);
      if (k >= 3 && k < 19) chk($sformatf("s%0d_rdata0", k), 32'(bus.rdata0), 32'h1300 + 32'(k - 3));
      next_cycle();
    end

    // reset in the cycle after a grant drops the in-flight read
    drive(1'b1, 16'h0400, 1'b0, 16'h0);
    @(negedge clock);
    chk("rm_gnt0", 32'(bus.gnt0), 32'd1);
    next_cycle();
    drive(1'b0, 16'h0, 1'b0, 16'h0);
    reset = 1'b1;
    #1;
    chk("rm_rst_rom_rd", 32'(bus.rom_rd), 32'd0);
    chk("rm_rst_rvalid0", 32'(bus.rvalid0), 32'd0);
    chk("rm_rst_rdata0", 32'(bus.rdata0), 32'd0);
    chk("rm_rst_rdata1", 32'(bus.rdata1), 32'd0);
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk($sformatf("rm%0d_rvalid0", k), 32'(bus.rvalid0), 32'd0);
      chk($sformatf("rm%0d_rvalid1", k), 32'(bus.rvalid1), 32'd0);
      chk($sformatf("rm%0d_rdata0", k), 32'(bus.rdata0), 32'd0);
      next_cycle();
    end

    // starvation guard with MAX_WAIT=4, three runs
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < 9; s++) begin
        if (s < 5)       drive(1'b1, 16'h0100, 1'b1, 16'h0200);
        else if (s == 5) drive(1'b1, 16'h0100, 1'b0, 16'h0);
        else             drive(1'b0, 16'h0, 1'b0, 16'h0);
        @(negedge clock);
        chk($sformatf("st%0d_%0d_gnt0", r, s), 32'(bus.gnt0), (s < 4 || s == 5) ? 32'd1 : 32'd0);
        chk($sformatf("st%0d_%0d_gnt1", r, s), 32'(bus.gnt1), (s == 4) ? 32'd1 : 32'd0);
        if (s == 4) chk($sformatf("st%0d_rom_addr", r), 32'(bus.rom_addr), 32'h0200);
        chk($sformatf("st%0d_%0d_rvalid0", r, s), 32'(bus.rvalid0),
            ((s >= 3 && s <= 6) || s == 8) ? 32'd1 : 32'd0);
        chk($sformatf("st%0d_%0d_rvalid1", r, s), 32'(bus.rvalid1), (s == 7) ? 32'd1 : 32'd0);
        if (s == 7) chk($sformatf("st%0d_rdata1", r), 32'(bus.rdata1), 32'h1200);
        if (s == 8) chk($sformatf("st%0d_rdata0", r), 32'(bus.rdata0), 32'h1100);
        next_cycle();
      end
    end

`ifdef ROM_ARBITER_STATS_EN
    @(negedge clock);
    chk("stats_forced_cnt", 32'(forced_cnt), 32'd3);
    chk("stats_grant_cnt1", grant_cnt1, 32'd3);
    chk("stats_grant_cnt0", grant_cnt0, 32'd15);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
